// File: rtl/sprite_dma_pkg.sv
// Shared definitions for the sprite attribute table DMA: table geometry,
// CPU register map, CTRL bit positions and the transfer state encoding.
package sprite_dma_pkg;

  localparam int SPR_COUNT  = 32;
  localparam int ITEM_BYTES = 4;
  localparam int LEN        = SPR_COUNT * ITEM_BYTES;
  localparam int IDX_W      = $clog2(LEN);
  localparam int SRC_W      = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  localparam logic [1:0] REG_SRC_LO = 2'd0;
  localparam logic [1:0] REG_SRC_HI = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_PROG   = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_SYNC  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_REQ,
    S_ADDR,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/sprite_dma_regs.sv
// CPU-facing register file for the sprite DMA: source address registers,
// combinational read mux and decode of the CTRL start/sync request.
module sprite_dma_regs
  import sprite_dma_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cpu_addr,
  input  logic             cpu_wr,
  input  logic [7:0]       cpu_din,
  input  logic             busy,
  input  logic             done_sticky,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       cpu_dout,
  output logic [SRC_W-1:0] src,
  output logic             start_req,
  output logic             sync_req
);

  logic [7:0] src_lo;
  logic [7:0] src_hi;

  // Source registers stay writable during a transfer; the FSM latches its own copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_lo <= 8'h00;
      src_hi <= 8'h00;
    end else if (cpu_wr) begin
      if (cpu_addr == REG_SRC_LO) src_lo <= cpu_din;
      if (cpu_addr == REG_SRC_HI) src_hi <= cpu_din;
    end
  end

  assign src       = {src_hi, src_lo};
  assign start_req = cpu_wr && (cpu_addr == REG_CTRL) && cpu_din[CTRL_START];
  assign sync_req  = cpu_din[CTRL_SYNC];

  always_comb begin
    cpu_dout = 8'h00;
    case (cpu_addr)
      REG_SRC_LO: cpu_dout = src_lo;
      REG_SRC_HI: cpu_dout = src_hi;
      REG_CTRL:   cpu_dout = {6'b0, done_sticky, busy};
      REG_PROG:   cpu_dout = {1'b0, idx};
      default:    cpu_dout = 8'h00;
    endcase
  end

endmodule

// File: rtl/sprite_dma.sv
// Copies the 128-byte sprite attribute table from CPU RAM into sprite RAM,
// optionally deferring the start to the next vblank rising edge.
module sprite_dma
  import sprite_dma_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             vblank,
  input  logic [1:0]       cpu_addr,
  input  logic             cpu_wr,
  input  logic [7:0]       cpu_din,
  output logic [7:0]       cpu_dout,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [SRC_W-1:0] ram_addr,
  input  logic [7:0]       ram_data_in,
  output logic [IDX_W-1:0] spriteram_addr,
  output logic [7:0]       spriteram_data_in,
  output logic             spriteram_wr,
  output logic             busy,
  output logic             done_irq
);

  state_t           state;
  state_t           next_state;
  logic [SRC_W-1:0] src;
  logic [SRC_W-1:0] src_lat;
  logic [IDX_W-1:0] idx;
  logic             start_req;
  logic             sync_req;
  logic             done_sticky;
  logic             vblank_last;
  logic             bus_req_next;

  sprite_dma_regs u_regs (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wr     (cpu_wr),
    .cpu_din    (cpu_din),
    .busy       (busy),
    .done_sticky(done_sticky),
    .idx        (idx),
    .cpu_dout   (cpu_dout),
    .src        (src),
    .start_req  (start_req),
    .sync_req   (sync_req)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start_req) next_state = sync_req ? S_ARM : S_REQ;
      S_ARM:   if (vblank && !vblank_last) next_state = S_REQ;
      S_REQ:   if (bus_gnt) next_state = S_ADDR;
      S_ADDR:  next_state = S_WAIT;
      S_WAIT:  next_state = S_WRITE;
      S_WRITE: next_state = (idx == LAST_IDX) ? S_DONE : S_ADDR;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // bus_req is registered from the next state so it rises as REQ is entered
  // and falls as DONE hands back to IDLE.
  always_comb begin
    busy         = (state != S_IDLE);
    bus_req_next = (next_state != S_IDLE) && (next_state != S_ARM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_last       <= 1'b0;
      bus_req           <= 1'b0;
      src_lat           <= '0;
      idx               <= '0;
      ram_addr          <= '0;
      spriteram_addr    <= '0;
      spriteram_data_in <= 8'h00;
      spriteram_wr      <= 1'b0;
      done_irq          <= 1'b0;
      done_sticky       <= 1'b0;
    end else begin
      vblank_last  <= vblank;
      bus_req      <= bus_req_next;
      spriteram_wr <= 1'b0;
      done_irq     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_req) begin
            src_lat     <= src;
            idx         <= '0;
            done_sticky <= 1'b0;
          end
        end
        S_ADDR: ram_addr <= src_lat + {{(SRC_W-IDX_W){1'b0}}, idx};
        S_WRITE: begin
          spriteram_addr    <= idx;
          spriteram_data_in <= ram_data_in;
          spriteram_wr      <= 1'b1;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        S_DONE: begin
          done_irq    <= 1'b1;
          done_sticky <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_dma.sv
// Directed bench for sprite_dma: expected sprite RAM writes go into a
// scoreboard queue and a negedge monitor pops them as the DUT writes.
module tb_sprite_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vblank = 1'b0;
  logic [1:0]  cpu_addr = 2'd0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data_in = 8'h00;
  logic [6:0]  spriteram_addr;
  logic [7:0]  spriteram_data_in;
  logic        spriteram_wr;
  logic        busy;
  logic        done_irq;

  typedef struct packed {
    logic [6:0]  sa;
    logic [7:0]  d;
    logic [15:0] ra;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [0:65535];
  logic [7:0] spr_model [0:127];
  int         total = 0;
  int         bad = 0;

  sprite_dma dut (
    .clk              (clk),
    .reset            (reset),
    .vblank           (vblank),
    .cpu_addr         (cpu_addr),
    .cpu_wr           (cpu_wr),
    .cpu_din          (cpu_din),
    .cpu_dout         (cpu_dout),
    .bus_req          (bus_req),
    .bus_gnt          (bus_gnt),
    .ram_addr         (ram_addr),
    .ram_data_in      (ram_data_in),
    .spriteram_addr   (spriteram_addr),
    .spriteram_data_in(spriteram_data_in),
    .spriteram_wr     (spriteram_wr),
    .busy             (busy),
    .done_irq         (done_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_data_in <= mem[ram_addr];

  // Scoreboard monitor: every sprite RAM write must match the head of the queue.
  always @(negedge clk) begin
    if (spriteram_wr) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write addr=%0d data=%02h ram_addr=%04h required=none",
                 spriteram_addr, spriteram_data_in, ram_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (spriteram_addr !== e.sa || spriteram_data_in !== e.d || ram_addr !== e.ra) begin
          bad++;
          $display("[TB] FAIL write got addr=%0d data=%02h ram_addr=%04h required addr=%0d data=%02h ram_addr=%04h",
                   spriteram_addr, spriteram_data_in, ram_addr, e.sa, e.d, e.ra);
        end
      end
      spr_model[spriteram_addr] = spriteram_data_in;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a;
    cpu_din  = d;
    cpu_wr   = 1'b1;
    @(negedge clk);
    cpu_wr   = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [7:0] v);
    cpu_addr = a;
    #1;
    v = cpu_dout;
  endtask

  task automatic pushEntry(input int i, input logic [7:0] d, input logic [15:0] ra);
    exp_t e;
    e.sa = 7'(i);
    e.d  = d;
    e.ra = ra;
    exp_q.push_back(e);
  endtask

  // Latency counts negedges after the current one; tails 20 cycles to catch extra pulses.
  task automatic waitDone(input int budget, output int latency, output int pulses);
    latency = -1;
    pulses  = 0;
    for (int c = 0; c < budget; c++) begin
      if (done_irq) begin
        if (latency < 0) latency = c;
        pulses++;
      end
      if (latency >= 0 && c > latency + 20) break;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] a;
    int          lat;
    int          pulses;
    bit          ok;

    for (int i = 0; i < 65536; i++) begin
      a = 16'(i);
      mem[i] = a[7:0] ^ a[15:8] ^ 8'h1A;
    end
    for (int i = 0; i < 128; i++) spr_model[i] = 8'h00;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_bus_req", bus_req, 0);
    checkOutput("rst_done_irq", done_irq, 0);
    checkOutput("rst_spr_wr", spriteram_wr, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    readReg(2'd0, v); checkOutput("rst_src_lo", v, 8'h00);
    readReg(2'd1, v); checkOutput("rst_src_hi", v, 8'h00);
    readReg(2'd2, v); checkOutput("rst_ctrl", v, 8'h00);
    readReg(2'd3, v); checkOutput("rst_prog", v, 8'h00);

    $display("[TB] basic copy from 0x4000");
    applyStimulus(2'd0, 8'h00);
    applyStimulus(2'd1, 8'h40);
    for (int i = 0; i < 128; i++) pushEntry(i, 8'(i) ^ 8'h5A, 16'h4000 + 16'(i));
    applyStimulus(2'd2, 8'h01);
    waitDone(600, lat, pulses);
    checkOutput("basic_latency", 32'(lat), 386);
    checkOutput("basic_pulses", 32'(pulses), 1);
    checkOutput("basic_q_empty", 32'(exp_q.size()), 0);
    readReg(2'd2, v); checkOutput("basic_ctrl", v, 8'h02);
    readReg(2'd3, v); checkOutput("basic_prog", v, 8'h7F);

    $display("[TB] ctrl write without start");
    applyStimulus(2'd2, 8'h02);
    repeat (5) @(negedge clk);
    checkOutput("nostart_busy", busy, 0);
    checkOutput("nostart_bus_req", bus_req, 0);
    readReg(2'd2, v); checkOutput("nostart_ctrl", v, 8'h02);

    $display("[TB] grant delayed 50 clocks");
    bus_gnt = 1'b0;
    for (int i = 0; i < 128; i++) pushEntry(i, 8'(i) ^ 8'h5A, 16'h4000 + 16'(i));
    applyStimulus(2'd2, 8'h01);
    ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (bus_req !== 1'b1 || ram_addr !== 16'h407F || busy !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("gnt_hold", ok, 1);
    bus_gnt = 1'b1;
    waitDone(600, lat, pulses);
    checkOutput("gnt_pulses", 32'(pulses), 1);
    checkOutput("gnt_q_empty", 32'(exp_q.size()), 0);

    $display("[TB] start synced to vblank");
    applyStimulus(2'd0, 8'h00);
    applyStimulus(2'd1, 8'h20);
    for (int i = 0; i < 128; i++) pushEntry(i, 8'(i) ^ 8'h3A, 16'h2000 + 16'(i));
    applyStimulus(2'd2, 8'h03);
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus_req !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("arm_no_req", ok, 1);
    vblank = 1'b1;
    @(negedge clk);
    checkOutput("arm_req_after_edge", bus_req, 1);
    repeat (30) @(negedge clk);
    vblank = 1'b0;
    waitDone(600, lat, pulses);
    checkOutput("arm_latency", 32'(lat), 356);
    checkOutput("arm_pulses", 32'(pulses), 1);
    checkOutput("arm_q_empty", 32'(exp_q.size()), 0);

    $display("[TB] source address wrap");
    applyStimulus(2'd0, 8'hF0);
    applyStimulus(2'd1, 8'hFF);
    for (int i = 0; i < 128; i++) begin
      a = 16'hFFF0 + 16'(i);
      pushEntry(i, a[7:0] ^ a[15:8] ^ 8'h1A, a);
    end
    applyStimulus(2'd2, 8'h01);
    waitDone(600, lat, pulses);
    checkOutput("wrap_latency", 32'(lat), 386);
    checkOutput("wrap_last_ram_addr", ram_addr, 16'h006F);
    checkOutput("wrap_q_empty", 32'(exp_q.size()), 0);

    $display("[TB] second start while busy");
    applyStimulus(2'd0, 8'h00);
    applyStimulus(2'd1, 8'h40);
    for (int i = 0; i < 128; i++) pushEntry(i, 8'(i) ^ 8'h5A, 16'h4000 + 16'(i));
    applyStimulus(2'd2, 8'h01);
    readReg(2'd2, v); checkOutput("busy_ctrl", v, 8'h01);
    repeat (122) @(negedge clk);
    readReg(2'd3, v); checkOutput("busy_prog40", v, 8'd40);
    applyStimulus(2'd2, 8'h01);
    applyStimulus(2'd0, 8'h99);
    waitDone(600, lat, pulses);
    checkOutput("busy_pulses", 32'(pulses), 1);
    checkOutput("busy_q_empty", 32'(exp_q.size()), 0);
    readReg(2'd0, v); checkOutput("busy_src_lo", v, 8'h99);

    $display("[TB] reset mid-transfer");
    for (int i = 0; i < 128; i++) spr_model[i] = 8'hEE;
    applyStimulus(2'd0, 8'h00);
    for (int i = 0; i < 64; i++) pushEntry(i, 8'(i) ^ 8'h5A, 16'h4000 + 16'(i));
    applyStimulus(2'd2, 8'h01);
    repeat (193) @(negedge clk);
    readReg(2'd3, v); checkOutput("rst_mid_prog64", v, 8'd64);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_mid_bus_req", bus_req, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_spr_wr", spriteram_wr, 0);
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (spriteram_wr !== 1'b0 || bus_req !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("rst_mid_quiet", ok, 1);
    checkOutput("rst_mid_q_empty", 32'(exp_q.size()), 0);
    checkOutput("rst_mid_entry63", spr_model[63], 8'd63 ^ 8'h5A);
    ok = 1'b1;
    for (int i = 64; i < 128; i++) if (spr_model[i] !== 8'hEE) ok = 1'b0;
    checkOutput("rst_mid_untouched", ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
